// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH-channel programmable clock divider and tick generator; define CLKDIV_SYNC_EN to add the sync_start phase-align input
module clkdiv_multi #(
  parameter int          NCH     = 4,
  parameter int          WIDTH   = 32,
  parameter int unsigned DEF_DIV = 49999999,
  localparam int         CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CCLK,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_wr,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_mode,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_start,
`endif
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   cfg_pending
);
  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEF_DIV);
  logic w_sync;
`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_start;
`else
  assign w_sync = 1'b0;
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_div, r_sdiv, w_ndiv;
    logic r_mode, r_smode, r_pend, r_clk, r_tick;
    logic w_wr, w_bnd, w_upd, w_take, w_nmode, w_mode;
    assign w_wr    = cfg_wr && (32'(cfg_ch) == i);
    assign w_bnd   = r_cnt == r_div;
    assign w_upd   = en[i] && (w_bnd || w_sync);
    // a write landing on the update cycle itself bypasses the shadow
    assign w_take  = en[i] ? (w_upd && (w_wr || r_pend)) : r_pend;
    assign w_ndiv  = (en[i] && w_wr) ? cfg_div : r_sdiv;
    assign w_nmode = (en[i] && w_wr) ? cfg_mode : r_smode;
    assign w_mode  = w_take ? w_nmode : r_mode;
    // phase counter and registered outputs; pulse mode drives high only on the boundary, 1->0 change restarts low
    always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_clk  <= 1'b0;
      end else begin
        r_cnt  <= (en[i] && !w_upd) ? r_cnt + WIDTH'(1) : '0;
        r_tick <= en[i] && w_bnd && !w_sync;
        r_clk  <= (!en[i] || w_sync) ? 1'b0 : w_bnd ? (w_mode || (!r_mode && !r_clk)) : (!r_mode && r_clk);
      end
    end
    // shadow config captured on write, promoted to active only at a period boundary, sync or while disabled
    always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
        r_div   <= DEF_W;
        r_mode  <= 1'b0;
        r_sdiv  <= DEF_W;
        r_smode <= 1'b0;
        r_pend  <= 1'b0;
      end else begin
        if (w_take) begin
          r_div  <= w_ndiv;
          r_mode <= w_nmode;
        end
        if (w_wr) begin
          r_sdiv  <= cfg_div;
          r_smode <= cfg_mode;
        end
        r_pend <= en[i] ? (!w_upd && (w_wr || r_pend)) : w_wr;
      end
    end
    assign clk_out[i]     = r_clk;
    assign tick[i]        = r_tick;
    assign cfg_pending[i] = r_pend;
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: randomized self-checking bench for clkdiv_multi against a countdown-based reference model
module tb_clkdiv_multi;
  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int DD  = 3;
  logic           CCLK = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_div;
  logic           cfg_mode;
  logic           sync;
  logic [NCH-1:0] clk_out, tick, cfg_pending;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int left;
    int div;
    bit mode;
    int sdiv;
    bit smode;
    bit pend;
    bit out;
    bit tk;
  } ch_t;
  ch_t m[NCH];
  always #5 CCLK = ~CCLK;
  clkdiv_multi #(.NCH(NCH), .WIDTH(W), .DEF_DIV(DD)) u_dut (
    .CCLK(CCLK),
    .rst_n(rst_n),
    .en(en),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
`ifdef CLKDIV_SYNC_EN
    .sync_start(sync),
`endif
    .clk_out(clk_out),
    .tick(tick),
    .cfg_pending(cfg_pending)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m[c] = '{left: DD, div: DD, mode: 0, sdiv: DD, smode: 0, pend: 0, out: 0, tk: 0};
  endtask
  // advance the reference by one CCLK edge using the inputs currently applied
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      bit om;
      wr = cfg_wr && (int'(cfg_ch) == c);
      if (!en[c]) begin
        if (m[c].pend) begin
          m[c].div  = m[c].sdiv;
          m[c].mode = m[c].smode;
        end
        if (wr) begin
          m[c].sdiv  = int'(cfg_div);
          m[c].smode = cfg_mode;
        end
        m[c].pend = wr;
        m[c].left = m[c].div;
        m[c].out  = 0;
        m[c].tk   = 0;
      end else if (sync || m[c].left == 0) begin
        if (wr) begin
          m[c].sdiv  = int'(cfg_div);
          m[c].smode = cfg_mode;
        end
        om = m[c].mode;
        if (wr || m[c].pend) begin
          m[c].div  = m[c].sdiv;
          m[c].mode = m[c].smode;
        end
        m[c].pend = 0;
        m[c].left = m[c].div;
        m[c].tk   = !sync;
        m[c].out  = sync ? 1'b0 : m[c].mode ? 1'b1 : om ? 1'b0 : !m[c].out;
      end else begin
        m[c].left--;
        m[c].tk = 0;
        if (m[c].mode) m[c].out = 0;
        if (wr) begin
          m[c].sdiv  = int'(cfg_div);
          m[c].smode = cfg_mode;
          m[c].pend  = 1;
        end
      end
    end
  endtask
  task automatic compare_all(input string tag);
    logic [NCH-1:0] e_clk, e_tk, e_pd;
    for (int c = 0; c < NCH; c++) begin
      e_clk[c] = m[c].out;
      e_tk[c]  = m[c].tk;
      e_pd[c]  = m[c].pend;
    end
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(e_clk));
    chk({tag, ".tick"}, 32'(tick), 32'(e_tk));
    chk({tag, ".pending"}, 32'(cfg_pending), 32'(e_pd));
  endtask
  task automatic cycle(input string tag);
    model_step();
    @(negedge CCLK);
    cfg_wr = 1'b0;
    sync   = 1'b0;
    compare_all(tag);
  endtask
  task automatic write(input int ch, input int d, input bit md);
    cfg_wr   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_div  = W'(d);
    cfg_mode = md;
  endtask
  initial begin
    logic [7:0] exp_clk, exp_tk;
    bit found;
    int n;
    en = '0; cfg_wr = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0; sync = 0;
    model_reset();
    repeat (3) @(negedge CCLK);
    chk("reset_clk", 32'(clk_out), 0);
    chk("reset_pend", 32'(cfg_pending), 0);
    rst_n = 1'b1;
    @(negedge CCLK);
    compare_all("reset");
    en = 3'b001;
    exp_clk = 8'b01111000;
    exp_tk  = 8'b10001000;
    for (int k = 0; k < 8; k++) begin
      cycle("div3");
      chk("div3_clk0", 32'(clk_out[0]), 32'(exp_clk[k]));
      chk("div3_tick0", 32'(tick[0]), 32'(exp_tk[k]));
      chk("div3_idle", 32'({clk_out[2:1], tick[2:1]}), 0);
    end
    repeat (2) cycle("mid");
    write(0, 1, 0);
    cycle("wr_mid");
    chk("wr_mid_pend", 32'(cfg_pending[0]), 1);
    repeat (12) cycle("div1");
    write(1, 0, 1);
    cycle("wr_ch1");
    en = 3'b011;
    repeat (6) cycle("pulse0");
    chk("pulse0_hi", 32'({clk_out[1], tick[1]}), 3);
    en = 3'b001;
    cycle("dis1");
    chk("dis1_lo", 32'({clk_out[1], tick[1]}), 0);
    en = 3'b011;
    repeat (3) cycle("reen1");
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m[0].left == 0) found = 1;
      else cycle("seek");
    end
    chk("bnd_found", 32'(found), 1);
    write(0, 5, 0);
    cycle("wr_bnd");
    chk("wr_bnd_pend", 32'(cfg_pending[0]), 0);
    n = 0;
    do begin
      cycle("hp6");
      n++;
    end while (!tick[0] && n < 20);
    chk("hp6_len", 32'(n), 6);
    write(3, 1, 1);
    cycle("bad_ch");
    chk("bad_ch_pend", 32'(cfg_pending), 0);
    repeat (4) cycle("bad_ch_run");
`ifdef CLKDIV_SYNC_EN
    en = '0;
    cycle("s_dis");
    write(0, 2, 0);
    cycle("s_w0");
    write(1, 4, 0);
    cycle("s_w1");
    cycle("s_apply");
    en = 3'b011;
    repeat (7) cycle("s_run");
    sync = 1'b1;
    cycle("sync");
    chk("sync_lo", 32'(clk_out[1:0]), 0);
    repeat (2) cycle("s_a");
    chk("sync_ch0_2", 32'(clk_out[0]), 0);
    cycle("s_b");
    chk("sync_ch0_3", 32'(clk_out[0]), 1);
    cycle("s_c");
    chk("sync_ch1_4", 32'(clk_out[1]), 0);
    cycle("s_d");
    chk("sync_ch1_5", 32'(clk_out[1]), 1);
`endif
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(39) == 0) en[c] = !en[c];
      if ($urandom_range(3) == 0) write($urandom_range(3), $urandom_range(5), 1'($urandom_range(1)));
`ifdef CLKDIV_SYNC_EN
      if ($urandom_range(49) == 0) sync = 1'b1;
`endif
      cycle("rand");
    end
    en = 3'b111;
    repeat (5) cycle("pre_rst");
    write(1, 2, 0);
    cycle("pre_rst_wr");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({clk_out, tick, cfg_pending}), 0);
    model_reset();
    @(negedge CCLK);
    compare_all("in_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
